pr_bus_arbiter: RTL
===================

// Module: pr_bus_arbiter
// PURPOSE
//  Shares the timer peripheral bus (Bridge PrAddr/PrWD/PrWE/PrRD) between two masters: M0 = CPU MEM stage,
//  M1 = DMA/debug loader. Round-robin arbitration with bounded bus lock, req/gnt/rvalid handshake,
//  address-window check, registered read return. Sits between the masters and the Bridge; Bridge unchanged.
// PARAMETERS
//  WIN_HI    24'h00007f  PrAddr[31:8] of the timer window (0x7F00-0x7F1F valid)
//  LOCK_MAX  4           max consecutive grants to one locked master before forced hand-over (>=1)
//  RST_OWNER 1           value of last_owner at reset (1 => M0 wins first contention)
// PORTS
//  clk        in   1   clock, all flops rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  mN_req     in   1   N=0,1: request; addr/we/wd/lock held stable until gnt
//  mN_we      in   1   1 = write, 0 = read
//  mN_addr    in   30  word address [31:2]
//  mN_wd      in   32  write data
//  mN_lock    in   1   keep bus for next request from same master
//  mN_gnt     out  1   one-cycle pulse in XFER cycle of mN's transaction
//  mN_rvalid  out  1   one-cycle pulse in RESP cycle; reads and writes both respond
//  mN_rd      out  32  read data, valid with rvalid (0 for writes/errors)
//  mN_err     out  1   with rvalid: address outside window, no bus access made
//  PrAddr     out  30  to Bridge
//  PrWD       out  32  to Bridge
//  PrWE       out  1   to Bridge; high only in XFER for a valid-window write
//  PrRD       in   32  from Bridge (combinational timer read)
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, last_owner=RST_OWNER, lock_cnt=0, all gnt/rvalid/err=0,
//    mN_rd=0, PrWE=0, PrAddr=0, PrWD=0.
//  - FSM IDLE -> XFER -> RESP -> (XFER | IDLE). Arbitration in IDLE and RESP only.
//  - IDLE: if any req, pick winner, register owner + its addr/we/wd -> XFER next cycle.
//  - XFER: PrAddr/PrWD from registered copy; owner gnt=1; PrWE=we & in_window; read samples
//    PrRD into rd register (0 if write or out-of-window); err register = ~in_window.
//  - RESP: owner rvalid=1 with rd/err; re-arbitrate: winner -> XFER, none -> IDLE.
//  - Latency: req high at edge k (IDLE) -> gnt in cycle k+1, rvalid in cycle k+2.
//    Sustained throughput one transaction per 2 cycles.
//  - in_window = (addr[31:8]==WIN_HI) & (addr[7:4]<=1).
//  - Round robin: both req -> master != last_owner wins; last_owner updated on every grant.
//  - Lock: if owner's lock=1 at arbitration and it requests and lock_cnt<LOCK_MAX-1, owner
//    wins regardless of RR, lock_cnt++; else normal RR, lock_cnt=0. Owner change clears lock_cnt.
//    lock_cnt saturates, never wraps. Lock ignored when other master idle (grant anyway, cnt reset).
//  - Requester drops req before gnt: ignored if dropped before arbitration edge; once registered,
//    transaction completes (gnt+rvalid still issued).
//  - Never gnt/rvalid to both masters in one cycle; never PrWE outside XFER.
//  - Reset mid-transaction: async clear; write in XFER not committed if reset low at that edge.
// STRUCTURE
//  - Shared include arb_defs.v: state encodings (IDLE/XFER/RESP), WIN_HI default, master IDs.
//  - Sub-module rr_arb2: 2-way round robin with lock counter (inputs req[1:0], lock, last_owner,
//    lock_cnt; outputs winner, valid, next lock_cnt). Top holds FSM, request registers, datapath.
// TESTING
//  - Reset: reset=0 mid-XFER write -> PrWE=0 immediately, all outputs 0, Timer preset unchanged.
//  - Single read: M0 read 0x7F08, PrRD=0x0000_0123 -> m0_gnt cycle k+1, m0_rvalid+rd=0x123 k+2.
//  - Contention: M0 and M1 req same edge after reset -> M0 first, M1 granted in following RESP;
//    sustained both -> grants alternate M0,M1,M0,M1.
//  - Lock: LOCK_MAX=4, M1 lock=1 with 6 back-to-back reqs, M0 req held -> M1 gets 4 grants,
//    then M0, then M1.
//  - Out of window: M1 write 0x7F40 data 0xFFFF_FFFF -> PrWE stays 0, m1_err=1, m1_rd=0.
//  - Write: M0 write 0x7F14 data 0x0000_0010 -> PrWE=1 one cycle, Timer2 preset reads back 0x10.

Source files
------------

// File: rtl/pr_bus_arbiter_pkg.sv
// pr_bus_arbiter shared types and constants.
// FSM encodings, timer window and master IDs.
package pr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [23:0] WIN_HI_DEF = 24'h00007f;
  localparam logic        M0_ID      = 1'b0;
  localparam logic        M1_ID      = 1'b1;
  localparam int          CNT_W      = 4;

  // Word address [31:2]: byte[31:8] is addr[29:6], byte[7:4] is addr[5:2].
  function automatic logic in_window(
    input logic [29:0] addr,
    input logic [23:0] win_hi
  );
    return (addr[29:6] == win_hi) && (addr[5:2] <= 4'd1);
  endfunction

endpackage

// File: rtl/pr_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with bounded lock.
// The last owner may keep the bus while it locks and the count allows.
module pr_bus_arbiter_rr_arb2
  import pr_bus_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic [1:0]       req,
  input  logic             lock,
  input  logic             last_owner,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic             winner,
  output logic             valid,
  output logic [CNT_W-1:0] lock_cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX - 1);

  logic both;
  logic hold;

  assign both  = &req;
  assign hold  = lock & (lock_cnt < CNT_LIM);
  assign valid = |req;

  // Lock only matters under contention; any other grant restarts the count.
  always_comb begin
    winner       = last_owner;
    lock_cnt_nxt = '0;
    unique case (1'b1)
      ~valid: begin
        winner       = last_owner;
        lock_cnt_nxt = lock_cnt;
      end
      both & hold: begin
        winner       = last_owner;
        lock_cnt_nxt = lock_cnt + 1'b1;
      end
      both & ~hold: begin
        winner = ~last_owner;
      end
      ^req: begin
        winner = req[1];
      end
    endcase
  end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master arbiter in front of the timer Bridge.
// IDLE -> XFER -> RESP FSM with a registered request and read return.
module pr_bus_arbiter
  import pr_bus_arbiter_pkg::*;
#(
  parameter logic [23:0] WIN_HI    = WIN_HI_DEF,
  parameter int          LOCK_MAX  = 4,
  parameter logic        RST_OWNER = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  output logic        m1_err,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD
);

  arb_state_e       state_q, state_d;
  logic             owner_q;
  logic             last_owner_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             we_q;
  logic [29:0]      addr_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd_q;
  logic             err_q;

  logic             arb_en;
  logic             arb_win;
  logic             arb_valid;
  logic [CNT_W-1:0] arb_cnt;
  logic             win_ok;
  logic             lock_sel;

  assign arb_en   = (state_q == IDLE) || (state_q == RESP);
  assign win_ok   = in_window(addr_q, WIN_HI);
  assign lock_sel = last_owner_q ? m1_lock : m0_lock;
  assign PrAddr   = addr_q;
  assign PrWD     = wd_q;

  pr_bus_arbiter_rr_arb2 #(
    .LOCK_MAX(LOCK_MAX)
  ) u_rr (
    .req         ({m1_req, m0_req}),
    .lock        (lock_sel),
    .last_owner  (last_owner_q),
    .lock_cnt    (lock_cnt_q),
    .winner      (arb_win),
    .valid       (arb_valid),
    .lock_cnt_nxt(arb_cnt)
  );

  // Next state plus per-master handshake and Bridge strobe.
  always_comb begin
    state_d   = state_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rd     = '0;
    m1_rd     = '0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    PrWE      = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = arb_valid ? XFER : IDLE;
      end
      XFER: begin
        state_d = RESP;
        m0_gnt  = (owner_q == M0_ID);
        m1_gnt  = (owner_q == M1_ID);
        PrWE    = we_q & win_ok;
      end
      RESP: begin
        state_d   = arb_valid ? XFER : IDLE;
        m0_rvalid = (owner_q == M0_ID);
        m1_rvalid = (owner_q == M1_ID);
        m0_rd     = (owner_q == M0_ID) ? rd_q : '0;
        m1_rd     = (owner_q == M1_ID) ? rd_q : '0;
        m0_err    = (owner_q == M0_ID) & err_q;
        m1_err    = (owner_q == M1_ID) & err_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, ownership and lock bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= RST_OWNER;
      lock_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (arb_en && arb_valid) begin
        owner_q      <= arb_win;
        last_owner_q <= arb_win;
        lock_cnt_q   <= arb_cnt;
      end
    end
  end

  // Request capture at arbitration, read/err capture in XFER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (arb_en && arb_valid) begin
        we_q   <= arb_win ? m1_we   : m0_we;
        addr_q <= arb_win ? m1_addr : m0_addr;
        wd_q   <= arb_win ? m1_wd   : m0_wd;
      end
      if (state_q == XFER) begin
        rd_q  <= (win_ok && !we_q) ? PrRD : '0;
        err_q <= ~win_ok;
      end
    end
  end

endmodule
